// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Requester order LOAD, JMP, ALU is also the round-robin order after reset.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREQ = 3;
    localparam int NREG = 1 << AW;

    localparam int REQ_LD  = 0;
    localparam int REQ_JMP = 1;
    localparam int REQ_ALU = 2;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{valid: 1'b0, rd: {AW{1'b0}}, data: {XLEN{1'b0}}};

    // First requester found scanning upward (with wrap) from start; one-hot result.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
        logic [2:0] g;
        g = 3'b000;
        case (start)
            2'd1: begin
                if (req[1])      g = 3'b010;
                else if (req[2]) g = 3'b100;
                else if (req[0]) g = 3'b001;
                else             g = 3'b000;
            end
            2'd2: begin
                if (req[2])      g = 3'b100;
                else if (req[0]) g = 3'b001;
                else if (req[1]) g = 3'b010;
                else             g = 3'b000;
            end
            default: begin
                if (req[0])      g = 3'b001;
                else if (req[1]) g = 3'b010;
                else if (req[2]) g = 3'b100;
                else             g = 3'b000;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant, pointer moves past the winner.
// No grant leaves the pointer where it is; reset suppresses grants and restarts at LOAD.
module rr_arbiter3
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [2:0] gnt_s;

    // Grant the first active requester at or after the pointer; nothing during reset.
    always_comb begin
        gnt_s = 3'b000;
        if (reset) begin
            gnt_s = 3'b000;
        end else begin
            gnt_s = rr_pick(req, ptr_q);
        end
    end

    // Advance the pointer to winner+1 (mod 3); hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (reset) begin
            ptr_d = 2'd0;
        end else begin
            case (gnt_s)
                3'b001:  ptr_d = 2'd1;
                3'b010:  ptr_d = 2'd2;
                3'b100:  ptr_d = 2'd0;
                default: ptr_d = ptr_q;
            endcase
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with load busy scoreboard and decode stall.
// Optional macro WB_BYPASS_EN adds forwarding of the registered write to decode
// (fwd1_hit/fwd2_hit/fwd_data) instead of stalling on it.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            jmp_valid,
    input  logic [AW-1:0]   jmp_rd,
    input  logic [XLEN-1:0] jmp_data,
    output logic            jmp_ready,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall,
    output logic [NREG-1:0] busy_vec
`ifdef WB_BYPASS_EN
    ,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_data
`endif
);

    wb_req_t         req_s [NREQ];
    logic [2:0]      req_vec_s;
    logic [2:0]      gnt_s;
    wb_req_t         win_s;

    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] busy_q,     busy_d;

    logic            hz1_s;
    logic            hz2_s;
    logic            fwd1_s;
    logic            fwd2_s;

    // Gather the three requesters into arbiter order.
    always_comb begin
        req_s[REQ_LD]  = '{valid: ld_valid,  rd: ld_rd,  data: ld_data};
        req_s[REQ_JMP] = '{valid: jmp_valid, rd: jmp_rd, data: jmp_data};
        req_s[REQ_ALU] = '{valid: alu_valid, rd: alu_rd, data: alu_data};
        req_vec_s      = {alu_valid, jmp_valid, ld_valid};
    end

    rr_arbiter3 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_vec_s),
        .gnt   (gnt_s)
    );

    // Pick the granted request's payload.
    always_comb begin
        win_s = WB_REQ_IDLE;
        case (gnt_s)
            3'b001:  win_s = req_s[REQ_LD];
            3'b010:  win_s = req_s[REQ_JMP];
            3'b100:  win_s = req_s[REQ_ALU];
            default: win_s = WB_REQ_IDLE;
        endcase
    end

    // Next write-port value: granted x0 writes are accepted but never enabled.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (reset) begin
            rf_we_d    = 1'b0;
            rf_waddr_d = {AW{1'b0}};
            rf_wdata_d = {XLEN{1'b0}};
        end else if (win_s.valid) begin
            rf_we_d    = (win_s.rd != {AW{1'b0}});
            rf_waddr_d = win_s.rd;
            rf_wdata_d = win_s.data;
        end else begin
            rf_we_d    = 1'b0;
        end
    end

    // Next scoreboard: load return clears, load issue sets, set applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (reset) begin
            busy_d = {NREG{1'b0}};
        end else begin
            if (gnt_s[REQ_LD]) begin
                busy_d[ld_rd] = 1'b0;
            end else begin
                busy_d[ld_rd] = busy_q[ld_rd];
            end
            if (ld_issue && (ld_issue_rd != {AW{1'b0}})) begin
                busy_d[ld_issue_rd] = 1'b1;
            end else begin
                busy_d[ld_issue_rd] = busy_d[ld_issue_rd];
            end
            busy_d[0] = 1'b0;
        end
    end

    // Write port and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {AW{1'b0}};
            rf_wdata_q <= {XLEN{1'b0}};
            busy_q     <= {NREG{1'b0}};
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    // Decode hazard per source; the registered write is either forwarded or waited out.
    always_comb begin
        fwd1_s = rf_we_q && (rf_waddr_q == rs1) && (rs1 != {AW{1'b0}});
        fwd2_s = rf_we_q && (rf_waddr_q == rs2) && (rs2 != {AW{1'b0}});
`ifdef WB_BYPASS_EN
        hz1_s  = (rs1 != {AW{1'b0}}) && busy_q[rs1] && !fwd1_s;
        hz2_s  = (rs2 != {AW{1'b0}}) && busy_q[rs2] && !fwd2_s;
`else
        hz1_s  = ((rs1 != {AW{1'b0}}) && busy_q[rs1]) || fwd1_s;
        hz2_s  = ((rs2 != {AW{1'b0}}) && busy_q[rs2]) || fwd2_s;
`endif
    end

    assign ld_ready  = gnt_s[REQ_LD];
    assign jmp_ready = gnt_s[REQ_JMP];
    assign alu_ready = gnt_s[REQ_ALU];
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_vec  = busy_q;
    assign stall     = hz1_s || hz2_s;
`ifdef WB_BYPASS_EN
    assign fwd1_hit  = fwd1_s;
    assign fwd2_hit  = fwd2_s;
    assign fwd_data  = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (default build, no forwarding ports).
// The driver predicts grants/stall/busy from a plain reference model and queues
// the expected write; a monitor pops and compares after each rising edge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r_v  [3];
    logic [4:0]  r_rd [3];
    logic [31:0] r_d  [3];
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        ld_ready, jmp_ready, alu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic [31:0] busy_vec;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // reference model state (what the registered outputs should be right now)
    int          m_ptr   = 0;
    logic [31:0] m_busy  = 32'd0;
    logic        m_we    = 1'b0;
    logic [4:0]  m_addr  = 5'd0;
    logic [2:0]  granted = 3'b000;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (r_v[0]),
        .ld_rd       (r_rd[0]),
        .ld_data     (r_d[0]),
        .ld_ready    (ld_ready),
        .jmp_valid   (r_v[1]),
        .jmp_rd      (r_rd[1]),
        .jmp_data    (r_d[1]),
        .jmp_ready   (jmp_ready),
        .alu_valid   (r_v[2]),
        .alu_rd      (r_rd[2]),
        .alu_data    (r_d[2]),
        .alu_ready   (alu_ready),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic hazard(input logic [4:0] rs);
        return (rs != 5'd0) && (m_busy[rs] || (m_we && (m_addr == rs)));
    endfunction

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic do_cycle();
        logic [2:0] g;
        int         idx;
        exp_t       e;
        #1;
        g = 3'b000;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (g == 3'b000 && r_v[idx]) g[idx] = 1'b1;
            end
        end
        check("ready", {29'd0, alu_ready, jmp_ready, ld_ready}, {29'd0, g});
        check("stall", {31'd0, stall}, {31'd0, (hazard(rs1) || hazard(rs2))});
        check("busy_vec", busy_vec, m_busy);
        e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0;
        if (reset) begin
            m_busy = 32'd0;
            m_ptr  = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (g[k]) begin
                    e.we   = (r_rd[k] != 5'd0);
                    e.addr = r_rd[k];
                    e.data = r_d[k];
                    m_ptr  = (k + 1) % 3;
                end
            end
            if (g[0]) m_busy[r_rd[0]] = 1'b0;
            if (ld_issue && ld_issue_rd != 5'd0) m_busy[ld_issue_rd] = 1'b1;
        end
        m_we   = e.we;
        m_addr = e.addr;
        exp_q.push_back(e);
        granted = g;
        @(negedge clk);
    endtask

    // Replace requests that were accepted or idle; hold the rest unchanged.
    task automatic refresh();
        for (int k = 0; k < 3; k++) begin
            if (granted[k] || !r_v[k]) begin
                r_v[k]  = ($urandom_range(0, 1) == 1);
                r_rd[k] = 5'($urandom_range(0, 7));
                r_d[k]  = $urandom;
            end
        end
        ld_issue    = ($urandom_range(0, 2) == 0);
        ld_issue_rd = 5'($urandom_range(0, 9));
        rs1         = 5'($urandom_range(0, 9));
        rs2         = 5'($urandom_range(0, 9));
    endtask

    // Monitor: compare the write port against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                if (e.we) begin
                    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                    check("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ld_issue = 1'b0; ld_issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        r_v[0] = 1'b1; r_rd[0] = 5'd1; r_d[0] = 32'h1111_0001;
        r_v[1] = 1'b1; r_rd[1] = 5'd2; r_d[1] = 32'h2222_0002;
        r_v[2] = 1'b1; r_rd[2] = 5'd3; r_d[2] = 32'h3333_0003;
        @(posedge clk);
        @(negedge clk);
        // reset held with all requesters pending: nothing accepted
        do_cycle();
        do_cycle();
        reset = 1'b0;
        check("reset_waddr", {27'd0, rf_waddr}, 32'd0);
        check("reset_wdata", rf_wdata, 32'd0);

        // all three held from reset: LD, JMP, ALU in order
        do_cycle(); r_v[0] = 1'b0;
        do_cycle(); r_v[1] = 1'b0;
        do_cycle(); r_v[2] = 1'b0;

        // single ALU write
        r_v[2] = 1'b1; r_rd[2] = 5'd5; r_d[2] = 32'hDEAD_BEEF;
        do_cycle(); r_v[2] = 1'b0;
        do_cycle();

        // load issue, decode hazard, load return clears it
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        do_cycle(); ld_issue = 1'b0; rs1 = 5'd7;
        do_cycle();
        r_v[0] = 1'b1; r_rd[0] = 5'd7; r_d[0] = 32'h0000_0777;
        do_cycle(); r_v[0] = 1'b0;
        do_cycle();
        do_cycle(); rs1 = 5'd0;

        // set and clear of the same register in one cycle: stays busy
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        do_cycle();
        r_v[0] = 1'b1; r_rd[0] = 5'd4; r_d[0] = 32'h0000_0444; rs2 = 5'd4;
        do_cycle(); r_v[0] = 1'b0; ld_issue = 1'b0;
        do_cycle(); rs2 = 5'd0;

        // x0 write and x0 load issue
        r_v[2] = 1'b1; r_rd[2] = 5'd0; r_d[2] = 32'h0000_1234;
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        do_cycle(); r_v[2] = 1'b0; ld_issue = 1'b0;
        do_cycle();

        // reset mid-operation with pointer away from LOAD and busy[9] set
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        r_v[1] = 1'b1; r_rd[1] = 5'd2; r_d[1] = 32'h2222_0022;
        do_cycle(); ld_issue = 1'b0;
        r_v[0] = 1'b1; r_rd[0] = 5'd1; r_d[0] = 32'h1111_0011;
        r_v[1] = 1'b1; r_rd[1] = 5'd2; r_d[1] = 32'h2222_0033;
        r_v[2] = 1'b1; r_rd[2] = 5'd3; r_d[2] = 32'h3333_0033;
        reset = 1'b1;
        do_cycle(); reset = 1'b0;
        do_cycle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            refresh();
            reset = ($urandom_range(0, 63) == 0);
            do_cycle();
        end

        // drain
        reset = 1'b0; ld_issue = 1'b0;
        r_v[0] = 1'b0; r_v[1] = 1'b0; r_v[2] = 1'b0;
        do_cycle();
        do_cycle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
